vx_csr_rmw_seq: RTL and testbench

- Initiator-side sequencer that turns decoded Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) into read and write transactions on the CSR data store's read_*/write_* port pair.
- Sits in the SFU between the issue stage and the CSR data store.
- Performs one atomic read-modify-write per request and returns the old CSR value to commit through a valid/ready response.

---
 rtl/vx_csr_rmw_seq.sv | 135 +++++++++++++
 tb/tb_vx_csr_rmw_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vx_csr_rmw_seq.sv
// Zicsr read-modify-write sequencer: one atomic CSR read (+ optional write) per request.
// Latency: read +1, write +2, response +3 (+2 with no write); req_ready only in IDLE, RESP holds until rsp_ready.
module vx_csr_rmw_seq #(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 32,
  parameter int ADDRW     = 12,
  parameter int UUIDW     = 44,
  parameter int NWW       = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [UUIDW-1:0]           req_uuid,
  input  logic [NWW-1:0]             req_wid,
  input  logic [NUM_LANES-1:0]       req_tmask,
  input  logic [1:0]                 req_op,
  input  logic [ADDRW-1:0]           req_addr,
  input  logic [NUM_LANES*DATAW-1:0] req_rs1,
  input  logic                       req_rs1_is_x0,
  input  logic                       req_rd_is_x0,
  output logic                       csr_read_enable,
  output logic [UUIDW-1:0]           csr_read_uuid,
  output logic [NWW-1:0]             csr_read_wid,
  output logic [ADDRW-1:0]           csr_read_addr,
  input  logic [DATAW-1:0]           csr_read_data_ro,
  input  logic [DATAW-1:0]           csr_read_data_rw,
  output logic                       csr_write_enable,
  output logic [UUIDW-1:0]           csr_write_uuid,
  output logic [NWW-1:0]             csr_write_wid,
  output logic [ADDRW-1:0]           csr_write_addr,
  output logic [DATAW-1:0]           csr_write_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [UUIDW-1:0]           rsp_uuid,
  output logic [NWW-1:0]             rsp_wid,
  output logic [NUM_LANES-1:0]       rsp_tmask,
  output logic [NUM_LANES*DATAW-1:0] rsp_data,
  output logic                       rsp_illegal,
  output logic                       busy
);

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  typedef struct packed {
    logic [UUIDW-1:0]     uuid;
    logic [NWW-1:0]       wid;
    logic [NUM_LANES-1:0] tmask;
    logic [1:0]           op;
    logic [ADDRW-1:0]     addr;
    logic [DATAW-1:0]     src;
    logic                 rs1_is_x0;
    logic                 rd_is_x0;
  } req_t;

  state_t             state, next_state;
  req_t               rq;
  logic [DATAW-1:0]   sel_src;
  logic [DATAW-1:0]   old_val, new_val, old_q, new_q;
  logic               skip_read, do_write, illegal, illegal_q;

  // Operand comes from the lowest active lane; an empty mask falls back to lane 0.
  always_comb begin
    sel_src = req_rs1[DATAW-1:0];
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (req_tmask[i]) sel_src = req_rs1[i*DATAW +: DATAW];
    end
  end

  always_comb begin
    skip_read = rq.rd_is_x0 && (rq.op == OP_RW);
    old_val   = skip_read ? '0 : (csr_read_data_ro | csr_read_data_rw);
    case (rq.op)
      OP_RW:   new_val = rq.src;
      OP_RS:   new_val = old_val | rq.src;
      OP_RC:   new_val = old_val & ~rq.src;
      default: new_val = old_val;
    endcase
    do_write = (rq.op == OP_RW) || !rq.rs1_is_x0;
    illegal  = (rq.op == 2'b11) || (do_write && (rq.addr[ADDRW-1 -: 2] == 2'b11));

    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = READ;
      READ:    next_state = (do_write && !illegal) ? WRITE : RESP;
      WRITE:   next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rq        <= '0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (req_valid && req_ready) begin
        rq <= '{uuid: req_uuid, wid: req_wid, tmask: req_tmask, op: req_op, addr: req_addr,
                src: sel_src, rs1_is_x0: req_rs1_is_x0, rd_is_x0: req_rd_is_x0};
      end
      if (state == READ) begin
        old_q     <= old_val;
        new_q     <= new_val;
        illegal_q <= illegal;
      end
    end
  end

  assign req_ready        = (state == IDLE);
  assign busy             = (state != IDLE);
  assign csr_read_enable  = (state == READ) && !skip_read;
  assign csr_read_uuid    = rq.uuid;
  assign csr_read_wid     = rq.wid;
  assign csr_read_addr    = rq.addr;
  assign csr_write_enable = (state == WRITE);
  assign csr_write_uuid   = rq.uuid;
  assign csr_write_wid    = rq.wid;
  assign csr_write_addr   = rq.addr;
  assign csr_write_data   = new_q;
  assign rsp_valid        = (state == RESP);
  assign rsp_uuid         = rq.uuid;
  assign rsp_wid          = rq.wid;
  assign rsp_tmask        = rq.tmask;
  assign rsp_data         = {NUM_LANES{old_q}};
  assign rsp_illegal      = illegal_q;

endmodule

// File: tb/tb_vx_csr_rmw_seq.sv
// Directed bench for vx_csr_rmw_seq: 4 lanes x 32 bits, outputs sampled on the falling edge.
module tb_vx_csr_rmw_seq;
  localparam int L = 4, W = 32, A = 12, U = 44, N = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [U-1:0] req_uuid = '0;
  logic [N-1:0] req_wid = '0;
  logic [L-1:0] req_tmask = '0;
  logic [1:0] req_op = '0;
  logic [A-1:0] req_addr = '0;
  logic [L*W-1:0] req_rs1 = '0;
  logic req_rs1_is_x0 = 1'b0, req_rd_is_x0 = 1'b0;
  logic csr_read_enable, csr_write_enable;
  logic [U-1:0] csr_read_uuid, csr_write_uuid, rsp_uuid;
  logic [N-1:0] csr_read_wid, csr_write_wid, rsp_wid;
  logic [A-1:0] csr_read_addr, csr_write_addr;
  logic [W-1:0] csr_read_data_ro = '0, csr_read_data_rw = '0, csr_write_data;
  logic rsp_valid, rsp_ready = 1'b1, rsp_illegal, busy;
  logic [L-1:0] rsp_tmask;
  logic [L*W-1:0] rsp_data;

  int checks = 0, errors = 0;
  logic [U-1:0] uuid_ctr = 44'h100;

  vx_csr_rmw_seq #(.NUM_LANES(L), .DATAW(W), .ADDRW(A), .UUIDW(U), .NWW(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
    .req_tmask(req_tmask), .req_op(req_op), .req_addr(req_addr), .req_rs1(req_rs1),
    .req_rs1_is_x0(req_rs1_is_x0), .req_rd_is_x0(req_rd_is_x0),
    .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid), .csr_read_wid(csr_read_wid),
    .csr_read_addr(csr_read_addr), .csr_read_data_ro(csr_read_data_ro), .csr_read_data_rw(csr_read_data_rw),
    .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid), .csr_write_wid(csr_write_wid),
    .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
    .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request from IDLE through response; stall = cycles rsp_ready is held low in RESP.
  task automatic txn(input logic [1:0] op, input logic [11:0] addr, input logic [1:0] wid,
                     input logic [3:0] tm, input logic [127:0] rs1, input logic rs1x0, input logic rdx0,
                     input logic [31:0] ro, input logic [31:0] rw,
                     input logic exp_rd, input logic exp_wr, input logic [31:0] exp_wdata,
                     input logic exp_ill, input logic [31:0] exp_old, input int stall);
    logic [127:0] exp_rsp;
    exp_rsp = {4{exp_old}};
    @(negedge clk);
    uuid_ctr = uuid_ctr + 44'd1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wid = wid; req_tmask = tm;
    req_rs1 = rs1; req_rs1_is_x0 = rs1x0; req_rd_is_x0 = rdx0; req_uuid = uuid_ctr;
    csr_read_data_ro = ro; csr_read_data_rw = rw;
    rsp_ready = (stall == 0);
    chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
    @(negedge clk);
    req_valid = 1'b0; req_rs1 = '0;
    chk("read_en", 128'(csr_read_enable), 128'(exp_rd));
    chk("read_addr", 128'(csr_read_addr), 128'(addr));
    chk("read_wid", 128'(csr_read_wid), 128'(wid));
    chk("write_en_in_read", 128'(csr_write_enable), 128'(1'b0));
    chk("req_ready_busy", 128'(req_ready), 128'(1'b0));
    @(negedge clk);
    if (exp_wr) begin
      chk("write_en", 128'(csr_write_enable), 128'(1'b1));
      chk("write_data", 128'(csr_write_data), 128'(exp_wdata));
      chk("write_addr", 128'(csr_write_addr), 128'(addr));
      chk("write_uuid", 128'(csr_write_uuid), 128'(uuid_ctr));
      chk("read_en_in_write", 128'(csr_read_enable), 128'(1'b0));
      chk("rsp_valid_early", 128'(rsp_valid), 128'(1'b0));
      @(negedge clk);
    end
    chk("write_en_off", 128'(csr_write_enable), 128'(1'b0));
    chk("rsp_valid", 128'(rsp_valid), 128'(1'b1));
    chk("rsp_data", rsp_data, exp_rsp);
    chk("rsp_illegal", 128'(rsp_illegal), 128'(exp_ill));
    chk("rsp_uuid", 128'(rsp_uuid), 128'(uuid_ctr));
    chk("rsp_tmask", 128'(rsp_tmask), 128'(tm));
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("stall_rsp_valid", 128'(rsp_valid), 128'(1'b1));
      chk("stall_rsp_data", rsp_data, exp_rsp);
      chk("stall_req_ready", 128'(req_ready), 128'(1'b0));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_done", 128'(rsp_valid), 128'(1'b0));
    chk("back_idle", 128'(req_ready), 128'(1'b1));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("rst_rd_en", 128'(csr_read_enable), 128'(1'b0));
    chk("rst_wr_en", 128'(csr_write_enable), 128'(1'b0));
    chk("rst_rsp_data", rsp_data, 128'(0));

    // CSRRW mscratch: old 0x1234, write 0xABCD
    txn(2'b00, 12'h340, 2'd2, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hABCD}, 1'b0, 1'b0,
        32'h0, 32'h1234, 1'b1, 1'b1, 32'hABCD, 1'b0, 32'h1234, 0);
    // CSRRS lane2 operand 0x0F, old = ro|rw = 0xF0 -> 0xFF
    txn(2'b01, 12'h340, 2'd1, 4'b0100, {32'h11, 32'h0F, 32'h22, 32'h33}, 1'b0, 1'b0,
        32'h30, 32'hC0, 1'b1, 1'b1, 32'hFF, 1'b0, 32'hF0, 0);
    // CSRRC lane2 operand 0x0F, old 0xFF -> 0xF0
    txn(2'b10, 12'h340, 2'd1, 4'b0100, {32'h11, 32'h0F, 32'hFF, 32'hFF}, 1'b0, 1'b0,
        32'h0, 32'hFF, 1'b1, 1'b1, 32'hF0, 1'b0, 32'hFF, 0);
    // CSRRS rs1=x0 on mcycle: read only, no write, response at cycle 2
    txn(2'b01, 12'hB00, 2'd0, 4'b1111, 128'h0, 1'b1, 1'b0,
        32'h5555, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h5555, 0);
    // CSRRW to mvendorid: illegal, no write
    txn(2'b00, 12'hF11, 2'd3, 4'b0001, {96'h0, 32'h9}, 1'b0, 1'b0,
        32'h600D, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h600D, 0);
    // reserved op: illegal, no write
    txn(2'b11, 12'h340, 2'd0, 4'b0001, {96'h0, 32'h9}, 1'b0, 1'b0,
        32'h0, 32'h42, 1'b1, 1'b0, 32'h0, 1'b1, 32'h42, 0);
    // CSRRW rd=x0: no read, write issued, old reported as 0
    txn(2'b00, 12'h340, 2'd1, 4'b0010, {32'h0, 32'h0, 32'hBEEF, 32'h1}, 1'b0, 1'b1,
        32'h0, 32'h777, 1'b0, 1'b1, 32'hBEEF, 1'b0, 32'h0, 0);
    // empty tmask selects lane 0
    txn(2'b00, 12'h340, 2'd0, 4'b0000, {32'h0, 32'h0, 32'h5A, 32'hA5}, 1'b0, 1'b0,
        32'h0, 32'h3, 1'b1, 1'b1, 32'hA5, 1'b0, 32'h3, 0);
    // response backpressure for 5 cycles
    txn(2'b01, 12'h340, 2'd2, 4'b1000, {32'h100, 96'h0}, 1'b0, 1'b0,
        32'h0, 32'h1, 1'b1, 1'b1, 32'h101, 1'b0, 32'h1, 5);

    // reset during WRITE: write drops, no response
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 12'h340; req_tmask = 4'b0001;
    req_rs1 = {96'h0, 32'hCAFE}; req_rs1_is_x0 = 1'b0; req_rd_is_x0 = 1'b0;
    csr_read_data_ro = 32'h0; csr_read_data_rw = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_write_en", 128'(csr_write_enable), 128'(1'b1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_write_en", 128'(csr_write_enable), 128'(1'b0));
    chk("mid_rst_busy", 128'(busy), 128'(1'b0));
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("mid_rst_rsp_data", rsp_data, 128'(0));
    @(negedge clk);
    chk("post_rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("post_rst_req_ready", 128'(req_ready), 128'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
